// File: rtl/amiga_pll_reconfig_ctrl.sv
// PAL/NTSC retune sequencer for the Amiga clock PLL: drives the ROM-based
// reconfiguration core, waits for relock, and holds the clock-enable domain meanwhile.
module amiga_pll_reconfig_ctrl #(
   parameter int SYNC_STAGES  = 2,
   parameter int CFG_TIMEOUT  = 1000,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int LOCK_SETTLE  = 16,
   parameter int MAX_RETRY    = 3
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       ntsc,
   input  logic       cfg_busy,
   input  logic       pll_locked,
   output logic       write_from_rom,
   output logic       rom_sel_ntsc,
   output logic       cfg_reconfig,
   output logic       cfg_reset,
   output logic       clk_hold,
   output logic       mode_ntsc,
   output logic       busy,
   output logic       error,
   output logic [1:0] retry_cnt
);
   localparam int SW    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int SET_W = $clog2(LOCK_SETTLE + 1);

   localparam logic [15:0]      CFG_TMO  = 16'(CFG_TIMEOUT);
   localparam logic [15:0]      LOCK_TMO = 16'(LOCK_TIMEOUT);
   localparam logic [SET_W-1:0] SETTLE_N = SET_W'(LOCK_SETTLE);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_LOAD      = 4'd1;
   localparam logic [3:0] S_LOAD_WAIT = 4'd2;
   localparam logic [3:0] S_WAIT_IDLE = 4'd3;
   localparam logic [3:0] S_RECONF    = 4'd4;
   localparam logic [3:0] S_CFG_WAIT  = 4'd5;
   localparam logic [3:0] S_LOCK_WAIT = 4'd6;
   localparam logic [3:0] S_FAIL      = 4'd7;
   localparam logic [3:0] S_DONE      = 4'd8;

   logic [SW-1:0]    ns_sync_q, ns_sync_d;
   logic [SW-1:0]    lk_sync_q, lk_sync_d;
   logic [3:0]       state_q, state_d;
   logic             target_q, target_d;
   logic [15:0]      timer_q, timer_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic             first_q, first_d;
   logic [1:0]       retry_q, retry_d;
   logic             error_q, error_d;
   logic             mode_q, mode_d;
   logic             hold_q, hold_d;
   logic             wfr_q, wfr_d;
   logic             rcf_q, rcf_d;
   logic             crst_q, crst_d;
   logic             busy_q, busy_d;

   logic             ns, lk;
   logic [15:0]      timer_dec;
   logic [SET_W-1:0] settle_inc;
   logic [1:0]       retry_inc;

   assign ns = ns_sync_q[SW-1];
   assign lk = lk_sync_q[SW-1];

   always_comb begin
      ns_sync_d  = {ns_sync_q[SW-2:0], ntsc};
      lk_sync_d  = {lk_sync_q[SW-2:0], pll_locked};
      state_d    = state_q;
      target_d   = target_q;
      timer_d    = timer_q;
      settle_d   = settle_q;
      first_d    = 1'b0;
      retry_d    = retry_q;
      error_d    = error_q;
      mode_d     = mode_q;
      hold_d     = hold_q;
      crst_d     = 1'b0;
      timer_dec  = timer_q - 16'd1;
      settle_inc = settle_q + SET_W'(1);
      retry_inc  = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

      case (state_q)
         S_IDLE: begin
            hold_d = ~lk;
            if ((ns != mode_q) && !error_q) begin
               target_d = ns;
               retry_d  = 2'd0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD:      state_d = S_LOAD_WAIT;
         S_LOAD_WAIT: state_d = S_WAIT_IDLE;
         S_WAIT_IDLE: if (!cfg_busy) state_d = S_RECONF;
         S_RECONF: begin
            timer_d = CFG_TMO;
            hold_d  = 1'b1;
            first_d = 1'b1;
            state_d = S_CFG_WAIT;
         end
         // The core raises busy a cycle after the pulse, so busy=0 on the first wait cycle is stale.
         S_CFG_WAIT: begin
            timer_d = timer_dec;
            if (!cfg_busy && !first_q) begin
               timer_d  = LOCK_TMO;
               settle_d = '0;
               state_d  = S_LOCK_WAIT;
            end else if (timer_dec <= 16'd1) begin
               crst_d  = 1'b1;
               state_d = S_FAIL;
            end
         end
         S_LOCK_WAIT: begin
            timer_d  = timer_dec;
            settle_d = lk ? settle_inc : '0;
            if (lk && (settle_inc >= SETTLE_N)) state_d = S_DONE;
            else if (timer_dec == 16'd0)        state_d = S_FAIL;
         end
         S_FAIL: begin
            retry_d = retry_inc;
            if (int'(retry_inc) < MAX_RETRY) begin
               state_d = S_LOAD;
            end else begin
               error_d = 1'b1;
               hold_d  = ~lk;
               state_d = S_IDLE;
            end
         end
         // A mode change that arrived mid-sequence is picked up here with the latest value.
         S_DONE: begin
            mode_d = target_q;
            hold_d = 1'b0;
            if (ns != target_q) begin
               target_d = ns;
               retry_d  = 2'd0;
               state_d  = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      wfr_d  = (state_d == S_LOAD);
      rcf_d  = (state_d == S_RECONF);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         ns_sync_q <= '0;
         lk_sync_q <= '0;
         state_q   <= S_IDLE;
         target_q  <= 1'b0;
         timer_q   <= '0;
         settle_q  <= '0;
         first_q   <= 1'b0;
         retry_q   <= 2'd0;
         error_q   <= 1'b0;
         mode_q    <= 1'b0;
         hold_q    <= 1'b1;
         wfr_q     <= 1'b0;
         rcf_q     <= 1'b0;
         crst_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         ns_sync_q <= ns_sync_d;
         lk_sync_q <= lk_sync_d;
         state_q   <= state_d;
         target_q  <= target_d;
         timer_q   <= timer_d;
         settle_q  <= settle_d;
         first_q   <= first_d;
         retry_q   <= retry_d;
         error_q   <= error_d;
         mode_q    <= mode_d;
         hold_q    <= hold_d;
         wfr_q     <= wfr_d;
         rcf_q     <= rcf_d;
         crst_q    <= crst_d;
         busy_q    <= busy_d;
      end
   end

   assign write_from_rom = wfr_q;
   assign rom_sel_ntsc   = target_q;
   assign cfg_reconfig   = rcf_q;
   assign cfg_reset      = crst_q;
   assign clk_hold       = hold_q;
   assign mode_ntsc      = mode_q;
   assign busy           = busy_q;
   assign error          = error_q;
   assign retry_cnt      = retry_q;

endmodule

// File: doc/amiga_pll_reconfig_ctrl.md
Name: amiga_pll_reconfig_ctrl

Overview:
- Sequencer for run-time PAL/NTSC retuning of the Amiga clock PLL.
- Watches the asynchronous ntsc select and drives the ROM-based PLL reconfiguration core (write_from_rom, reconfig, reset).
- Waits for the PLL to relock and holds the Amiga clock-enable domain while clocks are unstable.
- Adds busy timeout, bounded retry, and coalescing of mode changes that arrive during a sequence.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for ntsc (minimum 2).
- CFG_TIMEOUT, 1000, clk_in cycles allowed for the reconfig core to drop busy after a reconfig pulse.
- LOCK_TIMEOUT, 65535, clk_in cycles allowed for locked to settle after reconfiguration.
- LOCK_SETTLE, 16, consecutive locked-high cycles required before lock is declared stable.
- MAX_RETRY, 3, attempts per requested mode before error.

Ports:
- clk_in  input  1  controller clock, PLL reference (27 MHz).
- rst  input  1  reset, asynchronous, active-high.
- ntsc  input  1  requested mode (1=NTSC); asynchronous.
- cfg_busy  input  1  reconfig core busy.
- pll_locked  input  1  PLL locked, asynchronous.
- write_from_rom  output  1  one-cycle pulse: load scan chain from the selected ROM.
- rom_sel_ntsc  output  1  ROM select (target mode); stable for the whole sequence.
- cfg_reconfig  output  1  one-cycle pulse: apply scan chain.
- cfg_reset  output  1  one-cycle pulse: reset the reconfig core.
- clk_hold  output  1  high while the clocks are unstable; the consumer gates clk7_en and holds CPU reset.
- mode_ntsc  output  1  mode most recently applied successfully.
- busy  output  1  high whenever state is not IDLE.
- error  output  1  sticky; set when retries are exhausted.
- retry_cnt  output  2  attempts used in the current or last sequence.

Behaviour:
- Reset values: all pulse outputs 0, rom_sel_ntsc=0, mode_ntsc=0 (PAL, the PLL power-on configuration), clk_hold=1, busy=0, error=0, retry_cnt=0, state IDLE, synchroniser cleared.
- ntsc and pll_locked each pass through a SYNC_STAGES flop synchroniser; ns and lk denote the synchronised values.
- IDLE:
  - clk_hold = ~lk.
  - If ns != mode_ntsc and error=0: latch target=ns, drive rom_sel_ntsc=target, set retry_cnt=0, go LOAD.
  - error blocks new sequences until rst.
- LOAD: write_from_rom=1 for exactly one cycle; go LOAD_WAIT.
- LOAD_WAIT: fixed one cycle, covering ROM read latency; go WAIT_IDLE.
- WAIT_IDLE: when cfg_busy=0, go RECONF. No timeout in this state.
- RECONF: cfg_reconfig=1 for one cycle; load timer=CFG_TIMEOUT; set clk_hold=1; go CFG_WAIT.
- CFG_WAIT:
  - Decrement the timer each cycle.
  - If cfg_busy=0 and the cycle is not the first CFG_WAIT cycle: load timer=LOCK_TIMEOUT, clear the settle counter, go LOCK_WAIT.
  - If timer reaches 1 with busy still high: cfg_reset=1 for one cycle, go FAIL.
- LOCK_WAIT:
  - Settle counter increments while lk=1 and clears on lk=0.
  - Counter reaching LOCK_SETTLE → go DONE.
  - Timer expiry → go FAIL.
- FAIL: retry_cnt+1. If the new value is < MAX_RETRY, go LOAD with the same target. Otherwise set error=1, leave mode_ntsc unchanged, clk_hold=~lk, go IDLE.
- DONE:
  - mode_ntsc=target, clk_hold=0.
  - If ns != target (mode toggled mid-sequence), latch the new target and go LOAD with retry_cnt=0. Otherwise go IDLE.
  - Changes that arrive during a sequence are never lost; at most one further sequence follows, using the latest value.
- ns toggling and returning during a sequence: DONE sees ns==target and no extra sequence runs.
- Width rules:
  - Timer is 16 bits wide.
  - retry_cnt saturates at 3.
  - Settle counter width is clog2(LOCK_SETTLE+1).
- rst asserted at any point aborts immediately to reset values, with no cfg_reset pulse. The reconfig core is reset by the same rst at system level.
- Pulses never overlap. cfg_reconfig is never issued while cfg_busy=1 in the same cycle.

Test Plan:
- Reset, ntsc=0, busy=0, locked=1 → stays IDLE; clk_hold falls SYNC_STAGES+1 cycles after locked. No pulses; mode_ntsc=0.
- ntsc 0→1, busy high for 50 cycles after reconfig, locked low for 200 then high → write_from_rom at sync+1 with rom_sel_ntsc=1, then cfg_reconfig pulse. clk_hold stays high until 16 locked cycles have passed. mode_ntsc=1, retry_cnt=0.
- ntsc 0→1 with cfg_busy stuck high after reconfig → cfg_reset pulse 1000 cycles after cfg_reconfig. Three full attempts run, then error=1, retry_cnt=3, mode_ntsc=0; a later ntsc change is ignored.
- Busy stuck on the first attempt only → one cfg_reset, success on the second attempt, retry_cnt=1, mode_ntsc=1.
- ntsc 0→1, then 1→0 during LOCK_WAIT → after DONE, a second sequence runs with rom_sel_ntsc=0 and mode_ntsc ends at 0. A 1→0→1 glitch inside the sequence gives no second sequence.
- rst pulse during CFG_WAIT → all outputs at reset values next cycle. After release with ntsc=1, a fresh sequence starts.
